// File: rtl/l2_pkg.sv
// l2_pkg: shared types and geometry helpers
// for the parametrised write-back L2 cache.
package l2_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FLUSH = 2'd2,
    OP_RSVD  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    RESPOND,
    FLUSH_SCAN,
    FLUSH_WB
  } state_t;

  function automatic int off_w(input int lw);
    return $clog2(lw * 4);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(
    input int aw,
    input int sets,
    input int lw
  );
    return aw - idx_w(sets) - off_w(lw);
  endfunction

endpackage

// File: rtl/l2_victim_sel.sv
// l2_victim_sel: lowest invalid way first,
// otherwise the set's round-robin way.
module l2_victim_sel #(
  parameter int WAYS = 4,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  i_valid,
  input  logic [WAY_W-1:0] i_rr,
  output logic [WAY_W-1:0] o_way,
  output logic             o_use_rr
);

  // scan downwards so the lowest invalid way wins
  always_comb begin
    o_way    = i_rr;
    o_use_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) begin
        o_way    = WAY_W'(w);
        o_use_rr = 1'b0;
      end
    end
  end

endmodule

// File: rtl/l2_cache_param.sv
// l2_cache_param: write-back, write-allocate
// set-associative L2 with flush and RAM port.
module l2_cache_param
  import l2_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 8,
  parameter int WAYS       = 4,
  parameter int LINE_WORDS = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [32*LINE_WORDS-1:0]  req_wdata,
  output logic                      resp_valid,
  output logic [32*LINE_WORDS-1:0]  resp_rdata,
  output logic                      resp_hit,
  output logic [ADDR_W-3:0]         ram_addr,
  output logic                      ram_read_en,
  output logic                      ram_write_en,
  output logic [31:0]               ram_wdata,
  input  logic [31:0]               ram_rdata
);

  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int WK     = $clog2(LINE_WORDS);
  localparam int LINES  = SETS * WAYS;
  localparam int LN_W   = IDX_W + WAY_W;

  state_t             r_state;
  op_t                r_op;
  logic [TAG_W-1:0]   r_tag_q;
  logic [IDX_W-1:0]   r_set;
  logic [LINE_W-1:0]  r_wdata;
  logic [WAY_W-1:0]   r_way;
  logic [WK:0]        r_k;
  logic [LN_W-1:0]    r_line;
  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;
  logic [WAY_W-1:0]   r_rr [SETS];
  logic               r_resp_valid;
  logic               r_resp_hit;
  logic [LINE_W-1:0]  r_rdata;
  logic [LINE_W-1:0]  r_fill;
  logic [ADDR_W-3:0]  r_ram_addr;
  logic [TAG_W-1:0]   r_tags  [LINES];
  logic [LINE_W-1:0]  r_lines [LINES];

  logic [WAYS-1:0]    w_set_valid;
  logic               w_hit;
  logic [WAY_W-1:0]   w_hit_way;
  logic [WAY_W-1:0]   w_vic_way;
  logic               w_use_rr;
  logic [LN_W-1:0]    w_hit_idx;
  logic [LN_W-1:0]    w_vic_idx;
  logic [LN_W-1:0]    w_cur_idx;
  logic [LN_W-1:0]    w_wb_idx;
  logic [WK-1:0]      w_kw;
  logic [WK-1:0]      w_cap;
  logic               w_rd_en;
  logic               w_wr_en;
  logic               w_wb_last;
  logic               w_refill_last;
  logic               w_last_line;
  logic [ADDR_W-3:0]  w_rd_addr;
  logic [ADDR_W-3:0]  w_wb_addr;
  logic [31:0]        w_wb_word;
  logic [LINE_W-1:0]  w_fill_line;
  logic               w_unused_off;

  assign w_unused_off  = ^req_addr[OFF_W-1:0];
  assign w_hit_idx     = {r_set, w_hit_way};
  assign w_vic_idx     = {r_set, w_vic_way};
  assign w_cur_idx     = {r_set, r_way};
  assign w_wb_idx      = (r_state == FLUSH_WB) ? r_line : w_cur_idx;
  assign w_kw          = r_k[WK-1:0];
  assign w_cap         = WK'(r_k - 1'b1);
  assign w_rd_en       = (r_state == REFILL) && !r_k[WK];
  assign w_wr_en       = (r_state == WRITEBACK) || (r_state == FLUSH_WB);
  assign w_wb_last     = w_wr_en && (w_kw == WK'(LINE_WORDS - 1));
  assign w_refill_last = (r_state == REFILL) && r_k[WK];
  assign w_last_line   = (r_line == LN_W'(LINES - 1));
  assign w_rd_addr     = {r_tag_q, r_set, w_kw};
  assign w_wb_addr     = {r_tags[w_wb_idx], w_wb_idx[LN_W-1:WAY_W], w_kw};
  assign w_wb_word     = r_lines[w_wb_idx][32*w_kw +: 32];

  // RESPOND also accepts, so back-to-back hits issue every 2 cycles
  assign req_ready    = (r_state == IDLE) || (r_state == RESPOND);
  assign resp_valid   = r_resp_valid;
  assign resp_hit     = r_resp_hit;
  assign resp_rdata   = r_rdata;
  assign ram_read_en  = w_rd_en;
  assign ram_write_en = w_wr_en;
  assign ram_wdata    = w_wr_en ? w_wb_word : 32'd0;
  assign ram_addr     = w_rd_en ? w_rd_addr :
                        w_wr_en ? w_wb_addr : r_ram_addr;

  // tag compare across the ways of the latched set
  always_comb begin
    w_set_valid = '0;
    w_hit       = 1'b0;
    w_hit_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_set_valid[w] = r_valid[{r_set, WAY_W'(w)}];
      if (w_set_valid[w] &&
          r_tags[{r_set, WAY_W'(w)}] == r_tag_q) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // refilled line with the word arriving this cycle in the top slot
  always_comb begin
    w_fill_line = r_fill;
    w_fill_line[32*(LINE_WORDS-1) +: 32] = ram_rdata;
  end

  l2_victim_sel #(
    .WAYS (WAYS)
  ) u_victim (
    .i_valid  (w_set_valid),
    .i_rr     (r_rr[r_set]),
    .o_way    (w_vic_way),
    .o_use_rr (w_use_rr)
  );

  // tag/data storage and refill buffer, no reset needed
  always_ff @(posedge clk) begin
    if (r_state == REFILL && r_k != '0)
      r_fill[32*w_cap +: 32] <= ram_rdata;
    if (r_state == LOOKUP && w_hit && r_op == OP_WRITE)
      r_lines[w_hit_idx] <= r_wdata;
    if (w_refill_last) begin
      r_tags[w_cur_idx]  <= r_tag_q;
      r_lines[w_cur_idx] <= (r_op == OP_WRITE) ? r_wdata : w_fill_line;
    end
  end

  // control FSM with state bits and registered responses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_op         <= OP_READ;
      r_tag_q      <= '0;
      r_set        <= '0;
      r_wdata      <= '0;
      r_way        <= '0;
      r_k          <= '0;
      r_line       <= '0;
      r_valid      <= '0;
      r_dirty      <= '0;
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_rdata      <= '0;
      r_ram_addr   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_rd_en || w_wr_en) r_ram_addr <= ram_addr;
      unique case (r_state)
        IDLE, RESPOND: begin
          r_state <= IDLE;
          if (req_valid) begin
            r_op    <= op_t'(req_op);
            r_tag_q <= req_addr[ADDR_W-1 -: TAG_W];
            r_set   <= req_addr[OFF_W +: IDX_W];
            r_wdata <= req_wdata;
            r_line  <= '0;
            r_state <= (op_t'(req_op) == OP_FLUSH) ? FLUSH_SCAN : LOOKUP;
          end
        end
        LOOKUP: begin
          r_k <= '0;
          if (w_hit) begin
            if (r_op == OP_WRITE) r_dirty[w_hit_idx] <= 1'b1;
            else r_rdata <= r_lines[w_hit_idx];
            r_resp_hit   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= RESPOND;
          end else begin
            r_way <= w_vic_way;
            if (w_use_rr) r_rr[r_set] <= r_rr[r_set] + 1'b1;
            if (r_valid[w_vic_idx] && r_dirty[w_vic_idx])
              r_state <= WRITEBACK;
            else
              r_state <= REFILL;
          end
        end
        WRITEBACK: begin
          r_k <= r_k + 1'b1;
          if (w_wb_last) begin
            r_dirty[w_cur_idx] <= 1'b0;
            r_k                <= '0;
            r_state            <= REFILL;
          end
        end
        REFILL: begin
          r_k <= r_k + 1'b1;
          if (w_refill_last) begin
            r_valid[w_cur_idx] <= 1'b1;
            r_dirty[w_cur_idx] <= (r_op == OP_WRITE);
            if (r_op != OP_WRITE) r_rdata <= w_fill_line;
            r_resp_hit   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= RESPOND;
          end
        end
        FLUSH_SCAN: begin
          r_k <= '0;
          if (r_valid[r_line] && r_dirty[r_line]) begin
            r_state <= FLUSH_WB;
          end else if (w_last_line) begin
            r_resp_hit   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= RESPOND;
          end else begin
            r_line <= r_line + 1'b1;
          end
        end
        FLUSH_WB: begin
          r_k <= r_k + 1'b1;
          if (w_wb_last) begin
            r_dirty[r_line] <= 1'b0;
            if (w_last_line) begin
              r_resp_hit   <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= RESPOND;
            end else begin
              r_line  <= r_line + 1'b1;
              r_state <= FLUSH_SCAN;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
